// File: rtl/retire_trace_buffer.sv
// Retired-instruction trace capture buffer: arm/capture/halt control feeding a
// DEPTH-entry FIFO of retire records, drained through a valid/ready readout port.
module retire_trace_buffer #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     WRAP       = 0,
  parameter logic [XLEN-1:0] PC_LIMIT   = 'h200,
  parameter int unsigned     MAX_CYCLES = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   clr,
  input  logic                   ret_valid,
  input  logic [XLEN-1:0]        ret_pc,
  input  logic [31:0]            ret_instr,
  input  logic                   ret_we,
  input  logic [4:0]             ret_rd,
  input  logic [XLEN-1:0]        ret_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_we,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_wdata,
  output logic [31:0]            out_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted,
  output logic [2:0]             halt_cause,
  output logic [31:0]            cycle_count
);

  localparam int unsigned    AW          = $clog2(DEPTH);
  localparam int unsigned    CW          = AW + 1;
  localparam logic [CW-1:0]  FULL_COUNT  = CW'(DEPTH);
  localparam logic [31:0]    CYCLE_LIMIT = 32'(MAX_CYCLES);
  localparam logic [31:0]    CYCLE_MAX   = 32'hFFFF_FFFF;
  localparam logic [31:0]    INSTR_SELF_BRANCH = 32'h0000_0063;
  localparam logic [31:0]    INSTR_ZERO        = 32'h0000_0000;

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_BRANCH = 3'd1;
  localparam logic [2:0] CAUSE_ZERO   = 3'd2;
  localparam logic [2:0] CAUSE_PC     = 3'd3;
  localparam logic [2:0] CAUSE_CYCLES = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HALTED
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic [31:0]     cycle;
  } entry_t;

  state_t        state_reg, state_next;
  logic [2:0]    cause_reg, cause_next;
  logic [31:0]   cycle_reg, cycle_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic          mem_we;
  logic          push;
  logic          pop;
  logic          full;
  logic [31:0]   cycle_inc;
  logic [2:0]    cause_now;

  assign full      = (count_reg == FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign push      = ret_valid && (state_reg == CAPTURE);
  assign pop       = out_valid && out_ready;
  assign cycle_inc = (cycle_reg == CYCLE_MAX) ? cycle_reg : cycle_reg + 32'd1;

  // Register writes to x0 never architecturally happen, so record them as no-write.
  always_comb begin
    wr_entry.pc    = ret_pc;
    wr_entry.instr = ret_instr;
    wr_entry.we    = ret_we && (ret_rd != 5'd0);
    wr_entry.rd    = ret_rd;
    wr_entry.wdata = ret_wdata;
    wr_entry.cycle = cycle_reg;
  end

  // Entry-based causes outrank the cycle budget; a dropped entry still halts.
  always_comb begin
    cause_now = CAUSE_NONE;
    if (push && ret_instr == INSTR_SELF_BRANCH)
      cause_now = CAUSE_BRANCH;
    else if (push && ret_instr == INSTR_ZERO)
      cause_now = CAUSE_ZERO;
    else if (push && ret_pc >= PC_LIMIT)
      cause_now = CAUSE_PC;
    else if (state_reg == CAPTURE && cycle_inc == CYCLE_LIMIT)
      cause_now = CAUSE_CYCLES;
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    cycle_next = cycle_reg;
    if (clr) begin
      state_next = IDLE;
      cause_next = CAUSE_NONE;
      cycle_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm)
            state_next = CAPTURE;
        end
        CAPTURE: begin
          cycle_next = cycle_inc;
          if (cause_now != CAUSE_NONE) begin
            state_next = HALTED;
            cause_next = cause_now;
          end
        end
        HALTED: begin
          state_next = HALTED;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    mem_we        = 1'b0;
    if (clr) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (push && pop) begin
      mem_we      = 1'b1;
      wr_ptr_next = wr_ptr_reg + AW'(1);
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end else if (push) begin
      if (!full) begin
        mem_we      = 1'b1;
        wr_ptr_next = wr_ptr_reg + AW'(1);
        count_next  = count_reg + CW'(1);
      end else begin
        overflow_next = 1'b1;
        // When full, wr_ptr equals rd_ptr, so overwriting also retires the oldest.
        if (WRAP != 0) begin
          mem_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + AW'(1);
          rd_ptr_next = rd_ptr_reg + AW'(1);
        end
      end
    end else if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next  = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cause_reg    <= CAUSE_NONE;
      cycle_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cause_reg    <= cause_next;
      cycle_reg    <= cycle_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Entry storage carries no reset; validity is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr_reg] <= wr_entry;
  end

  assign head = mem[rd_ptr_reg];

  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_we      = head.we;
  assign out_rd      = head.rd;
  assign out_wdata   = head.wdata;
  assign out_cycle   = head.cycle;
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign halted      = (state_reg == HALTED);
  assign halt_cause  = cause_reg;
  assign cycle_count = cycle_reg;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Drives three buffer configurations (16/stop, 4/stop, 4/overwrite) with shared
// stimulus and compares each against a queue-based reference model.
module tb_retire_trace_buffer;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm, clr, ret_valid, ret_we, out_ready;
  logic [31:0] ret_pc, ret_instr, ret_wdata;
  logic [4:0]  ret_rd;

  logic        ov  [NI];
  logic [31:0] opc [NI];
  logic [31:0] oins[NI];
  logic        owe [NI];
  logic [4:0]  ord [NI];
  logic [31:0] owd [NI];
  logic [31:0] ocy [NI];
  logic        ovf [NI];
  logic        ohl [NI];
  logic [2:0]  ohc [NI];
  logic [31:0] occ [NI];
  logic [4:0]  cnt0;
  logic [2:0]  cnt1, cnt2;
  logic [4:0]  cnt [NI];

  assign cnt[0] = cnt0;
  assign cnt[1] = {2'b00, cnt1};
  assign cnt[2] = {2'b00, cnt2};

  retire_trace_buffer #(.XLEN(32), .DEPTH(16), .WRAP(0), .PC_LIMIT(32'h200), .MAX_CYCLES(50)) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .clr(clr),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_we(ret_we),
    .ret_rd(ret_rd), .ret_wdata(ret_wdata),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_pc(opc[0]), .out_instr(oins[0]), .out_we(owe[0]), .out_rd(ord[0]),
    .out_wdata(owd[0]), .out_cycle(ocy[0]),
    .count(cnt0), .overflow(ovf[0]), .halted(ohl[0]), .halt_cause(ohc[0]), .cycle_count(occ[0])
  );

  retire_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(0), .PC_LIMIT(32'h200), .MAX_CYCLES(50)) dut1 (
    .clk(clk), .rst(rst), .arm(arm), .clr(clr),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_we(ret_we),
    .ret_rd(ret_rd), .ret_wdata(ret_wdata),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_pc(opc[1]), .out_instr(oins[1]), .out_we(owe[1]), .out_rd(ord[1]),
    .out_wdata(owd[1]), .out_cycle(ocy[1]),
    .count(cnt1), .overflow(ovf[1]), .halted(ohl[1]), .halt_cause(ohc[1]), .cycle_count(occ[1])
  );

  retire_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(1), .PC_LIMIT(32'h200), .MAX_CYCLES(50)) dut2 (
    .clk(clk), .rst(rst), .arm(arm), .clr(clr),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_we(ret_we),
    .ret_rd(ret_rd), .ret_wdata(ret_wdata),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_pc(opc[2]), .out_instr(oins[2]), .out_we(owe[2]), .out_rd(ord[2]),
    .out_wdata(owd[2]), .out_cycle(ocy[2]),
    .count(cnt2), .overflow(ovf[2]), .halted(ohl[2]), .halt_cause(ohc[2]), .cycle_count(occ[2])
  );

  // Reference model: one queue of records per configuration plus control status.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] cyc;
  } ent_t;

  ent_t        q0[$], q1[$], q2[$];
  int          mstate [NI];  // 0 idle, 1 capturing, 2 halted
  bit          movf   [NI];
  int          mcause [NI];
  logic [31:0] mcyc   [NI];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qhead(int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpush(int k, ent_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic void qpop(int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void model_reset(int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
    mstate[k] = 0;
    movf[k]   = 1'b0;
    mcause[k] = 0;
    mcyc[k]   = '0;
  endfunction

  function automatic void model_step(int k);
    int   depth = (k == 0) ? 16 : 4;
    bit   wrap  = (k == 2);
    bit   pop, push;
    int   cause;
    ent_t e, h;
    if (!rst || clr) begin
      model_reset(k);
      return;
    end
    pop  = (qsize(k) > 0) && out_ready;
    push = (mstate[k] == 1) && ret_valid;
    if (pop && k == 0) begin
      h = qhead(0);
      $display("pop   pc=%08h instr=%08h we=%0d rd=%0d wdata=%08h cycle=%0d",
               h.pc, h.instr, h.we, h.rd, h.wdata, h.cyc);
    end
    if (push) begin
      e.pc = ret_pc; e.instr = ret_instr; e.rd = ret_rd; e.wdata = ret_wdata;
      e.we = (ret_rd == 5'd0) ? 1'b0 : ret_we;
      e.cyc = mcyc[k];
      if (pop) begin
        qpop(k); qpush(k, e);
      end else if (qsize(k) < depth) begin
        qpush(k, e);
      end else begin
        movf[k] = 1'b1;
        if (wrap) begin qpop(k); qpush(k, e); end
      end
    end else if (pop) begin
      qpop(k);
    end
    if (mstate[k] == 1) begin
      cause = 0;
      if (push) begin
        if (ret_instr == 32'h63)       cause = 1;
        else if (ret_instr == 32'h0)   cause = 2;
        else if (ret_pc >= 32'h200)    cause = 3;
      end
      if (mcyc[k] != 32'hFFFF_FFFF) mcyc[k] = mcyc[k] + 1;
      if (cause == 0 && mcyc[k] == 32'd50) cause = 4;
      if (cause != 0) begin
        mstate[k] = 2;
        mcause[k] = cause;
      end
    end else if (mstate[k] == 0 && arm) begin
      mstate[k] = 1;
    end
  endfunction

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("valid%0d", k), ov[k], qsize(k) > 0);
      check($sformatf("count%0d", k), cnt[k], qsize(k));
      if (qsize(k) > 0)
        check($sformatf("head%0d", k), {opc[k], oins[k], owe[k], ord[k], owd[k], ocy[k]}, qhead(k));
      check($sformatf("overflow%0d", k), ovf[k], movf[k]);
      check($sformatf("halted%0d", k), ohl[k], mstate[k] == 2);
      check($sformatf("cause%0d", k), ohc[k], mcause[k]);
      check($sformatf("cycles%0d", k), occ[k], mcyc[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd);
    ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_rd = rd;
    ret_we = 1'b1; ret_wdata = $urandom;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) model_reset(k);
    check("rst_count", cnt[0], 0);
    check("rst_valid", ov[0], 0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; clr = 1'b0; ret_valid = 1'b0; ret_we = 1'b0;
    out_ready = 1'b0; ret_pc = '0; ret_instr = '0; ret_wdata = '0; ret_rd = '0;
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) model_reset(k);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Three retires ending in a self-branch halt.
    do_clr(); do_arm();
    retire(32'h0, 32'h00500093, 5'd1);
    retire(32'h4, 32'h00300113, 5'd2);
    retire(32'h8, 32'h00000063, 5'd0);
    check("self_branch_halted", ohl[0], 1);
    check("self_branch_cause", ohc[0], 1);
    check("self_branch_count", cnt[0], 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("self_branch_out_cycle", ocy[0], i);
      check("self_branch_out_pc", opc[0], 4 * i);
      tick();
    end
    out_ready = 1'b0;

    // Clear out of HALTED, re-arm, first record carries cycle 0.
    do_clr();
    check("clr_halted", ohl[0], 0);
    do_arm();
    check("rearm_cycle", occ[0], 0);
    retire(32'h40, 32'h13, 5'd3);
    check("rearm_first_cycle", ocy[0], 0);

    // Six pushes with no readout: stop-on-full versus overwrite-oldest.
    do_clr(); do_arm();
    for (int i = 0; i < 6; i++) retire(4 * i, 32'h13, 5'(i + 1));
    check("stop_count", cnt[1], 4);
    check("stop_overflow", ovf[1], 1);
    check("stop_head_pc", opc[1], 0);
    check("wrap_count", cnt[2], 4);
    check("wrap_overflow", ovf[2], 1);
    check("deep_count", cnt[0], 6);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wrap_pop_pc", opc[2], 8 + 4 * i);
      tick();
    end
    out_ready = 1'b0;

    // Cycle budget halt with no retirement traffic.
    do_clr(); do_arm();
    repeat (50) tick();
    check("budget_halted", ohl[0], 1);
    check("budget_cause", ohc[0], 4);
    check("budget_cycles", occ[0], 50);

    // Zero instruction at PC_LIMIT: cause 2 wins over cause 3.
    do_clr(); do_arm();
    retire(32'h200, 32'h0, 5'd4);
    check("zero_instr_cause", ohc[0], 2);

    // Full buffer with simultaneous push and pop.
    do_clr(); do_arm();
    for (int i = 0; i < 4; i++) retire(4 * i, 32'h13, 5'd5);
    out_ready = 1'b1;
    retire(32'h10, 32'h13, 5'd6);
    out_ready = 1'b0;
    check("full_pp_count", cnt[1], 4);
    check("full_pp_overflow", ovf[1], 0);
    check("full_pp_head", opc[1], 4);
    check("full_pp_wrap_overflow", ovf[2], 0);

    // Asynchronous reset in the middle of a capture.
    do_clr(); do_arm();
    for (int i = 0; i < 3; i++) retire(4 * i, 32'h13, 5'd7);
    check("pre_rst_count", cnt[0], 3);
    async_reset();

    // Randomized traffic.
    for (int round = 0; round < 24; round++) begin
      int ready_pct = $urandom_range(0, 100);
      int len = $urandom_range(20, 80);
      do_clr(); do_arm();
      for (int c = 0; c < len; c++) begin
        int sel = $urandom_range(0, 39);
        ret_valid = ($urandom_range(0, 99) < 60);
        ret_pc    = 32'($urandom_range(0, 'h83)) << 2;
        ret_instr = (sel == 0) ? 32'h63 : (sel == 1) ? 32'h0 : (sel < 20) ? 32'h13 : $urandom;
        ret_rd    = 5'($urandom_range(0, 31));
        ret_we    = 1'($urandom_range(0, 1));
        ret_wdata = $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        arm       = ($urandom_range(0, 99) < 3);
        clr       = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 199) == 0) begin
          async_reset();
        end else begin
          tick();
        end
      end
      ret_valid = 1'b0; arm = 1'b0; clr = 1'b0; out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
